// File: rtl/rtype_issue_ctrl.sv
// Issue stage for the 8-bit R-type ALU: validates RV32 R-type words, reads operands
// from a 32x8 register file, holds them for the ALU, then writes the low result byte back.
module rtype_issue_ctrl #(
  parameter int ALU_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             rf_wr_en,
  input  logic [4:0]       rf_wr_addr,
  input  logic [7:0]       rf_wr_data,
  output logic [16:0]      alu_opcode,
  output logic [7:0]       alu_in_1,
  output logic [7:0]       alu_in_2,
  input  logic [31:0]      alu_result,
  output logic             wb_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  cnt_r;
  logic [4:0]  rd_r;
  logic [7:0]  rf_r [32];
  logic        legal_s;
  logic        accept_s;

  function automatic logic is_legal(input logic [31:0] word);
    logic op_ok;
    logic plain_ok;
    logic sub_ok;
    op_ok    = (word[6:0] == 7'b0110011);
    plain_ok = (word[31:25] == 7'b0000000);
    sub_ok   = (word[31:25] == 7'b0100000) && (word[14:12] == 3'b000);
    return op_ok && (plain_ok || sub_ok);
  endfunction

  assign legal_s  = is_legal(instr);
  assign accept_s = (state_r == IDLE) && instr_valid && legal_s;

  // Next-state logic; ISSUE exits when the wait counter has reached 1.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = ISSUE;
        else          next_state_s = IDLE;
      end
      ISSUE: begin
        if (cnt_r == 4'd1) next_state_s = WB;
        else               next_state_s = ISSUE;
      end
      WB:      next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with handshake/status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      instr_ready <= 1'b1;
      wb_done     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      instr_ready <= (next_state_s == IDLE);
      wb_done     <= (next_state_s == WB);
      illegal     <= (state_r == IDLE) && instr_valid && !legal_s;
    end
  end

  // Operand capture, wait counter and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= 17'd0;
      alu_in_1   <= 8'd0;
      alu_in_2   <= 8'd0;
      rd_r       <= 5'd0;
      cnt_r      <= 4'd0;
      retired    <= '0;
    end else begin
      if (accept_s) begin
        alu_opcode <= {instr[31:25], instr[14:12], instr[6:0]};
        alu_in_1   <= rf_r[instr[19:15]];
        alu_in_2   <= rf_r[instr[24:20]];
        rd_r       <= instr[11:7];
        cnt_r      <= 4'(ALU_WAIT);
      end else if (state_r == ISSUE) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_r == WB) retired <= retired + CNT_W'(1);
      else               retired <= retired;
    end
  end

  // Register file; entry 0 is never written so x0 reads as zero, writeback beats preload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 8'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if ((state_r == WB) && (rd_r == 5'(i)))       rf_r[i] <= alu_result[7:0];
        else if (rf_wr_en && (rf_wr_addr == 5'(i)))   rf_r[i] <= rf_wr_data;
        else                                          rf_r[i] <= rf_r[i];
      end
    end
  end

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Scoreboard bench for rtype_issue_ctrl: the driver pushes expectations from a register-file
// model, a negedge monitor pops them whenever wb_done or illegal appears.
module tb_rtype_issue_ctrl;
  localparam int W  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [7:0]    rf_wr_data;
  logic [16:0]   alu_opcode;
  logic [7:0]    alu_in_1;
  logic [7:0]    alu_in_2;
  logic [31:0]   alu_result;
  logic          wb_done;
  logic          illegal;
  logic [CW-1:0] retired;
  logic [23:0]   salt = 24'd0;

  rtype_issue_ctrl #(.ALU_WAIT(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_opcode(alu_opcode), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_result(alu_result), .wb_done(wb_done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // ALU stand-in: RV32 semantics on zero-extended bytes, upper bits scrambled every cycle.
  function automatic logic [31:0] alu_fn(input logic [16:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = {24'd0, a};
    y = {24'd0, b};
    case (op[9:7])
      3'b000:  return op[15] ? x - y : x + y;
      3'b001:  return x << y[4:0];
      3'b010:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011:  return (x < y) ? 32'd1 : 32'd0;
      3'b100:  return x ^ y;
      3'b101:  return x >> y[4:0];
      3'b110:  return x | y;
      default: return x & y;
    endcase
  endfunction

  always @(posedge clk) salt <= 24'($urandom);
  assign alu_result = alu_fn(alu_opcode, alu_in_1, alu_in_2) ^ {salt, 8'h00};

  typedef struct {
    logic [16:0]   op;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          ill_q[$];
  logic [7:0]    m_rf [32];
  logic [CW-1:0] m_ret;
  logic [16:0]   last_op;
  logic [7:0]    last_a;
  logic [7:0]    last_b;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] w);
    if (w[6:0] != 7'b0110011) return 1'b0;
    if (w[31:25] == 7'b0000000) return 1'b1;
    return (w[31:25] == 7'b0100000) && (w[14:12] == 3'b000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 8'd0;
    m_ret   = '0;
    last_op = 17'd0;
    last_a  = 8'd0;
    last_b  = 8'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    wait_idle();
    rf_wr_en = 1'b1; rf_wr_addr = a; rf_wr_data = d;
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    if (a != 5'd0) m_rf[a] = d;
  endtask

  // Presents one instruction until accepted; an optional preload shares the acceptance edge.
  task automatic issue(input logic [31:0] w, input bit pre_en, input logic [4:0] pa,
                       input logic [7:0] pd, output int acc_cyc);
    exp_t        e;
    bit          ok;
    bit          r;
    int          n;
    logic [31:0] res;
    ok = m_legal(w);
    if (pre_en) wait_idle();
    if (ok) begin
      e.op = {w[31:25], w[14:12], w[6:0]};
      e.a = m_rf[w[19:15]];
      e.b = m_rf[w[24:20]];
      e.ret = m_ret;
      exp_q.push_back(e);
    end else begin
      e.op = last_op; e.a = last_a; e.b = last_b; e.ret = m_ret;
      ill_q.push_back(e);
    end
    instr = w; instr_valid = 1'b1;
    rf_wr_en = pre_en; rf_wr_addr = pa; rf_wr_data = pd;
    n = 0;
    forever begin
      r = instr_ready;
      @(posedge clk); #1;
      rf_wr_en = 1'b0;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    acc_cyc = cyc;
    instr_valid = 1'b0;
    if (pre_en && pa != 5'd0) m_rf[pa] = pd;
    if (ok) begin
      res = alu_fn(e.op, e.a, e.b);
      if (w[11:7] != 5'd0) m_rf[w[11:7]] = res[7:0];
      m_ret++;
      last_op = e.op; last_a = e.a; last_b = e.b;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5)       w[31:25] = 7'b0000000;
    else if (k < 7) begin
      w[31:25] = 7'b0100000;
      if (k == 5) w[14:12] = 3'b000;
    end
    if (k != 9) w[6:0] = 7'b0110011;
    return w;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a writeback or a rejection.
  logic prev_ready = 1'b1;
  int   fall_cyc = 0;
  bit   post_wb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b1;
      post_wb = 1'b0;
    end else begin
      if (post_wb) chk("ready_after_wb", {31'd0, instr_ready}, 32'd1);
      post_wb = 1'b0;
      if (prev_ready && !instr_ready) fall_cyc = cyc;
      prev_ready = instr_ready;
      if (wb_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("alu_opcode", alu_opcode, e.op);
          chk("alu_in_1", alu_in_1, e.a);
          chk("alu_in_2", alu_in_2, e.b);
          chk("retired", retired, e.ret);
          chk("wb_latency", cyc - fall_cyc, W);
        end
        post_wb = 1'b1;
      end
      if (illegal) begin
        if (ill_q.size() == 0) begin
          chk("spurious_illegal", 32'd1, 32'd0);
        end else begin
          e = ill_q.pop_front();
          chk("ill_opcode_hold", alu_opcode, e.op);
          chk("ill_in_1_hold", alu_in_1, e.a);
          chk("ill_in_2_hold", alu_in_2, e.b);
          chk("ill_retired", retired, e.ret);
          chk("ill_ready", {31'd0, instr_ready}, 32'd1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    logic [7:0] d;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
    rf_wr_en = 1'b0; rf_wr_addr = 5'd0; rf_wr_data = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_opcode", alu_opcode, 32'd0);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    preload(5'd1, 8'd5); preload(5'd2, 8'd3);
    issue(32'h002081B3, 1'b0, 5'd0, 8'd0, a0);               // ADD x3,x1,x2
    issue(32'h00018333, 1'b0, 5'd0, 8'd0, a0);               // ADD x6,x3,x0 reads x3
    preload(5'd1, 8'd3); preload(5'd2, 8'd5);
    issue(32'h40208233, 1'b0, 5'd0, 8'd0, a0);               // SUB x4,x1,x2
    issue(32'h00020333, 1'b0, 5'd0, 8'd0, a0);               // ADD x6,x4,x0 reads 0xFE
    issue(32'h4020D1B3, 1'b0, 5'd0, 8'd0, a0);               // illegal SRA-like
    issue(32'h00208033, 1'b0, 5'd0, 8'd0, a0);               // ADD x0,x1,x2
    issue(32'h001002B3, 1'b0, 5'd0, 8'd0, a0);               // ADD x5,x0,x1
    issue(32'h002081B3, 1'b0, 5'd0, 8'd0, a0);
    issue(32'h00310233, 1'b0, 5'd0, 8'd0, a1);
    chk("back_to_back_gap", a1 - a0, W + 2);

    // Preload collides with writeback to the same rd: the writeback must win.
    wait_idle();
    issue(32'h002083B3, 1'b0, 5'd0, 8'd0, a0);               // ADD x7,x1,x2
    repeat (W) @(posedge clk);
    #1;
    chk("collide_in_wb", {31'd0, wb_done}, 32'd1);
    rf_wr_en = 1'b1; rf_wr_addr = 5'd7; rf_wr_data = 8'hA5;
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    issue(32'h00038433, 1'b0, 5'd0, 8'd0, a0);               // ADD x8,x7,x0

    // Reset in the middle of ISSUE drops the instruction.
    wait_idle();
    issue(32'h002084B3, 1'b0, 5'd0, 8'd0, a0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_opcode", alu_opcode, 32'd0);
    chk("mid_rst_in_1", alu_in_1, 32'd0);
    chk("mid_rst_in_2", alu_in_2, 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) issue(rand_instr() & 32'h01FFFFFF, 1'b0, 5'd0, 8'd0, a0);

    // Randomized traffic; the narrow retire counter wraps several times.
    for (int i = 0; i < 150; i++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       preload(5'($urandom), d);
        1:       issue(rand_instr(), 1'b1, 5'($urandom), d, a0);
        default: issue(rand_instr(), 1'b0, 5'd0, 8'd0, a0);
      endcase
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("ill_q_drained", ill_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
